stepper_move_sequencer: RTL and testbench

STEPPER_MOVE_SEQUENCER -- requirements
Module: stepper_move_sequencer

---
 rtl/stepper_move_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_stepper_move_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_move_sequencer.sv
// Trapezoidal-profile stepper move sequencer: accepts one move command, drives
// direction then a ramped train of step pulses, and reports completion or abort.
module stepper_move_sequencer #(
    parameter logic [15:0] START_PERIOD = 16'd50000,
    parameter logic [15:0] MIN_PERIOD   = 16'd2,
    parameter logic [15:0] ACCEL_DELTA  = 16'd500,
    parameter logic [7:0]  DIR_SETUP    = 8'd50
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_period,
    input  logic        abort,
    output logic        step_enable,
    output logic        direction,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] steps_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ACCEL, S_CRUISE, S_DECEL, S_FINISH
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic [15:0] r_cur, w_cur_nxt;
    logic [15:0] r_target, w_target_nxt;
    logic [15:0] r_remaining, w_remaining_nxt;
    logic [15:0] r_ramp_steps, w_ramp_steps_nxt;
    logic [15:0] r_steps_done, w_steps_done_nxt;
    logic        r_direction, w_direction_nxt;
    logic        r_aborted, w_aborted_nxt;

    logic        w_moving;
    logic        w_tick;
    logic        w_pulse;
    logic [15:0] w_rem_dec;
    logic [15:0] w_cur_up;
    logic [15:0] w_cur_down;
    logic [15:0] w_setup_last;

    function automatic logic [15:0] f_clamp_period(input logic [15:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    // Slow down: min(cur + delta, START_PERIOD), computed wide so it cannot wrap.
    function automatic logic [15:0] f_ramp_up(input logic [15:0] cur);
        logic [16:0] sum;
        sum = {1'b0, cur} + {1'b0, ACCEL_DELTA};
        return (sum > {1'b0, START_PERIOD}) ? START_PERIOD : sum[15:0];
    endfunction

    // Speed up: max(cur - delta, floor), without borrowing below zero.
    function automatic logic [15:0] f_ramp_down(input logic [15:0] cur,
                                               input logic [15:0] floor_p);
        logic [16:0] lim;
        lim = {1'b0, floor_p} + {1'b0, ACCEL_DELTA};
        return ({1'b0, cur} <= lim) ? floor_p : (cur - ACCEL_DELTA);
    endfunction

    assign w_moving     = (r_state == S_ACCEL) || (r_state == S_CRUISE) || (r_state == S_DECEL);
    assign w_tick       = w_moving && (r_timer == r_cur - 16'd1);
    assign w_pulse      = w_tick && !abort;
    assign w_rem_dec    = r_remaining - 16'd1;
    assign w_cur_up     = f_ramp_up(r_cur);
    assign w_cur_down   = f_ramp_down(r_cur, r_target);
    assign w_setup_last = {8'd0, DIR_SETUP} - 16'd1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_direction  <= 1'b0;
            r_aborted    <= 1'b0;
            r_steps_done <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_direction  <= w_direction_nxt;
            r_aborted    <= w_aborted_nxt;
            r_steps_done <= w_steps_done_nxt;
        end
    end

    // Profile datapath needs no reset: it is always reloaded on acceptance.
    always_ff @(posedge clock) begin
        r_cur        <= w_cur_nxt;
        r_target     <= w_target_nxt;
        r_remaining  <= w_remaining_nxt;
        r_ramp_steps <= w_ramp_steps_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_cur_nxt        = r_cur;
        w_target_nxt     = r_target;
        w_remaining_nxt  = r_remaining;
        w_ramp_steps_nxt = r_ramp_steps;
        w_steps_done_nxt = r_steps_done;
        w_direction_nxt  = r_direction;
        w_aborted_nxt    = r_aborted;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt      = (cmd_steps == 16'd0) ? S_FINISH : S_SETUP;
                    w_remaining_nxt  = cmd_steps;
                    w_direction_nxt  = cmd_dir;
                    w_target_nxt     = f_clamp_period(cmd_period);
                    w_steps_done_nxt = '0;
                    w_ramp_steps_nxt = '0;
                    w_aborted_nxt    = 1'b0;
                    w_timer_nxt      = '0;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    w_state_nxt   = S_FINISH;
                    w_aborted_nxt = 1'b1;
                end else if (r_timer == w_setup_last) begin
                    w_timer_nxt = '0;
                    if (r_target < START_PERIOD) begin
                        w_cur_nxt   = START_PERIOD;
                        w_state_nxt = S_ACCEL;
                    end else begin
                        w_cur_nxt   = r_target;
                        w_state_nxt = S_CRUISE;
                    end
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            S_ACCEL, S_CRUISE, S_DECEL: begin
                if (abort) begin
                    w_state_nxt   = S_FINISH;
                    w_aborted_nxt = 1'b1;
                end else if (w_tick) begin
                    w_timer_nxt      = '0;
                    w_remaining_nxt  = w_rem_dec;
                    w_steps_done_nxt = r_steps_done + 16'd1;
                    // Begin decelerating once the steps left fit the ramp already climbed.
                    if (w_rem_dec == 16'd0) begin
                        w_state_nxt = S_FINISH;
                    end else if ((r_state != S_DECEL) && (r_ramp_steps != 16'd0) &&
                                 (w_rem_dec <= r_ramp_steps)) begin
                        w_state_nxt = S_DECEL;
                        w_cur_nxt   = w_cur_up;
                    end else if (r_state == S_ACCEL) begin
                        w_cur_nxt        = w_cur_down;
                        w_ramp_steps_nxt = r_ramp_steps + 16'd1;
                        if (w_cur_down == r_target) begin
                            w_state_nxt = S_CRUISE;
                        end
                    end else if (r_state == S_DECEL) begin
                        w_cur_nxt = w_cur_up;
                    end
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready   = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_FINISH);
        step_enable = w_pulse;
        direction   = r_direction;
        aborted     = r_aborted;
        steps_done  = r_steps_done;
    end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Bench for stepper_move_sequencer: a table of move profiles checked pulse by
// pulse through a spacing scoreboard, plus abort and mid-move reset sequences.
module tb_stepper_move_sequencer;

    localparam int SETUP_CYC = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic        cmd_dir;
    logic [15:0] cmd_period;
    logic        abort;
    logic        step_enable;
    logic        direction;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] steps_done;

    stepper_move_sequencer #(
        .START_PERIOD(16'd100),
        .MIN_PERIOD  (16'd2),
        .ACCEL_DELTA (16'd10),
        .DIR_SETUP   (8'd4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step_enable(step_enable),
        .direction  (direction),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_done (steps_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int steps;
        int period;
        int dir;
        int n;
        int off;
    } vec_t;

    vec_t tv[9];
    int   pool[$];
    int   exp_q[$];
    int   cyc = 0;
    int   last_evt = 0;
    int   pulse_cnt = 0;
    int   pulse_base = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every pulse is matched against the next expected spacing.
    always @(negedge clock) begin
        if (step_enable) begin
            pulse_cnt++;
            check("pulse_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("pulse_spacing", cyc - last_evt, exp_q.pop_front());
            end
            last_evt = cyc;
        end
    end

    task automatic start_cmd(input int idx);
        cmd_valid  = 1'b1;
        cmd_steps  = 16'(tv[idx].steps);
        cmd_period = 16'(tv[idx].period);
        cmd_dir    = tv[idx].dir[0];
        check("cmd_ready_accept", cmd_ready, 1);
        for (int k = 0; k < tv[idx].n; k++) begin
            exp_q.push_back((k == 0) ? SETUP_CYC + pool[tv[idx].off] : pool[tv[idx].off + k]);
        end
        last_evt   = cyc;
        pulse_base = pulse_cnt;
        @(posedge clock); #1;
        check("busy_after_accept", busy, 1);
        check("dir_after_accept", direction, tv[idx].dir);
        check("ready_low_when_busy", cmd_ready, 0);
    endtask

    task automatic wait_done(input int exp_steps, input int exp_ab, input int exp_cyc);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 5000) begin
            @(negedge clock);
            n++;
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("done_cycle", cyc, (exp_cyc < 0) ? last_evt + 1 : exp_cyc);
            check("steps_done", steps_done, exp_steps);
            check("aborted", aborted, exp_ab);
            check("pulse_count", pulse_cnt - pulse_base, exp_steps);
            check("pending_pulses", exp_q.size(), 0);
        end
        @(posedge clock); #1;
        check("done_one_cycle", done, 0);
        check("ready_in_idle", cmd_ready, 1);
        check("busy_in_idle", busy, 0);
    endtask

    task automatic wait_pulses(input int cnt);
        int w;
        w = 0;
        while ((pulse_cnt - pulse_base) < cnt && w < 3000) begin
            @(posedge clock); #1;
            w++;
        end
        check("reach_pulse_count", pulse_cnt - pulse_base, cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int abort_cyc;
        int quiet;
        int acc;

        pool = {100, 90, 80, 70, 70, 70, 70, 80, 90, 100,
                100, 90, 80, 90,
                150, 150, 150,
                100, 90, 80, 70, 60, 50, 40, 30, 20, 10, 2, 2,
                12, 22, 32, 42, 52, 62, 72, 82, 92, 100,
                100, 95, 95, 100,
                100, 100,
                100,
                100, 90, 100};
        tv[0] = '{10,  70, 1, 10, 0};
        tv[1] = '{ 4,  70, 0,  4, 0};
        tv[2] = '{ 0,   1, 1,  0, 0};
        tv[3] = '{ 3, 150, 0,  3, 0};
        tv[4] = '{22,   1, 1, 22, 0};
        tv[5] = '{ 4,  95, 0,  4, 0};
        tv[6] = '{ 2, 100, 1,  2, 0};
        tv[7] = '{ 1,  70, 0,  1, 0};
        tv[8] = '{ 3,   1, 1,  3, 0};
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            tv[i].off = acc;
            acc += tv[i].n;
        end

        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_dir    = 1'b0;
        cmd_period = '0;
        abort      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_step_enable", step_enable, 0);
        check("rst_direction", direction, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_steps_done", steps_done, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 9; i++) begin
            start_cmd(i);
            cmd_valid = 1'b0;
            wait_done(tv[i].steps, 0, -1);
        end

        // Abort after the 5th pulse; abort stays high into IDLE and must not block acceptance.
        start_cmd(0);
        cmd_valid = 1'b0;
        wait_pulses(5);
        abort     = 1'b1;
        abort_cyc = cyc;
        exp_q.delete();
        wait_done(5, 1, abort_cyc + 1);
        start_cmd(7);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        wait_done(1, 0, -1);

        // cmd_valid held across a move with new fields: only taken once back in IDLE.
        start_cmd(1);
        cmd_steps  = 16'd10;
        cmd_period = 16'd70;
        cmd_dir    = 1'b1;
        wait_done(4, 0, -1);
        start_cmd(0);
        wait_pulses(4);
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        exp_q.delete();
        @(posedge clock); #1;
        check("midrst_step_enable", step_enable, 0);
        check("midrst_direction", direction, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_aborted", aborted, 0);
        check("midrst_steps_done", steps_done, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        reset_n = 1'b1;
        quiet = 0;
        repeat (150) begin
            @(negedge clock);
            if (done || step_enable) quiet++;
        end
        check("quiet_after_reset", quiet, 0);
        @(posedge clock); #1;
        start_cmd(6);
        cmd_valid = 1'b0;
        wait_done(2, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
